inst_rom_loader: RTL and testbench

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

---
 rtl/inst_rom_loader.sv | 100 ++++++++++
 tb/tb_inst_rom_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Instruction ROM loader: streams a program into on-chip memory, then
// serves combinational fetches to the CPU while holding it in reset until loaded.
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  input  logic [31:0]           ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  input  logic                  reload_i,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  cpu_rst_o,
  output logic [DEPTH_LOG2:0]   loaded_words_o,
  output logic                  err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LAST_PTR = (DEPTH_LOG2 + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    ERR
  } state_t;

  state_t                  state;
  logic [DEPTH_LOG2:0]     wptr;
  logic [31:0]             mem [DEPTH];
  logic                    we;
  logic [DEPTH_LOG2-1:0]   ridx;
  logic                    hit;
  logic                    addr_unused;

  // Handshake flags are flops so the CPU never sees a path from inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      wptr       <= '0;
      ld_ready_o <= 1'b1;
      cpu_rst_o  <= 1'b1;
      err_o      <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (ld_valid_i) begin
            wptr <= wptr + 1'b1;
            if (ld_last_i) begin
              state      <= RUN;
              ld_ready_o <= 1'b0;
              cpu_rst_o  <= 1'b0;
            end else if (wptr == LAST_PTR) begin
              state      <= ERR;
              ld_ready_o <= 1'b0;
              err_o      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (reload_i) begin
            state      <= LOAD;
            wptr       <= '0;
            ld_ready_o <= 1'b1;
            cpu_rst_o  <= 1'b1;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state      <= ERR;
          ld_ready_o <= 1'b0;
          cpu_rst_o  <= 1'b1;
          err_o      <= 1'b1;
        end
      endcase
    end
  end

  assign we = ld_valid_i & ld_ready_o & ~rst;

  // Program storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wptr[DEPTH_LOG2-1:0]] <= ld_data_i;
    end
  end

  assign ridx = rom_addr_i[DEPTH_LOG2+1:2];
  assign hit  = (state == RUN) & rom_ce_i & ({1'b0, ridx} < wptr);

  assign rom_data_o     = hit ? mem[ridx] : 32'h0;
  assign loaded_words_o = wptr;

  assign addr_unused = ^{rom_addr_i[31:DEPTH_LOG2+2], rom_addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: load, fetch, reload, overflow
// and asynchronous reset, with expected fetch data queued in a scoreboard.
module tb_inst_rom_loader;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        reload;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        cpu_rst;
  logic [6:0]  loaded;
  logic        err;

  int          n_checks;
  int          n_errors;
  logic [31:0] sb_q [$];

  inst_rom_loader #(.DEPTH_LOG2(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_valid_i     (ld_valid),
    .ld_data_i      (ld_data),
    .ld_last_i      (ld_last),
    .ld_ready_o     (ld_ready),
    .reload_i       (reload),
    .rom_ce_i       (rom_ce),
    .rom_addr_i     (rom_addr),
    .rom_data_o     (rom_data),
    .cpu_rst_o      (cpu_rst),
    .loaded_words_o (loaded),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rdy,
                         input logic crst, input logic er,
                         input logic [6:0] lw);
    chk({tag, ".ready"}, 64'(ld_ready), 64'(rdy));
    chk({tag, ".cpu_rst"}, 64'(cpu_rst), 64'(crst));
    chk({tag, ".err"}, 64'(err), 64'(er));
    chk({tag, ".loaded"}, 64'(loaded), 64'(lw));
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic ce, input logic [31:0] exp);
    @(negedge clk);
    rom_addr = a;
    rom_ce   = ce;
    sb_q.push_back(exp);
    #1;
    chk(tag, 64'(rom_data), 64'(sb_q.pop_front()));
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    reload   = 1'b0;
    rom_ce   = 1'b1;
    rom_addr = '0;

    #3;
    chk_ctl("reset", 1'b1, 1'b1, 1'b0, 7'd0);
    chk("reset.rom", 64'(rom_data), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic 4-word program
    beat(32'h3401_0001, 1'b0);
    beat(32'h3402_0002, 1'b0);
    beat(32'h0022_1820, 1'b0);
    chk_ctl("load3", 1'b1, 1'b1, 1'b0, 7'd3);
    rd("load3.rom", 32'h8, 1'b1, 32'h0);
    beat(32'h0000_0000, 1'b1);
    chk_ctl("run4", 1'b0, 1'b0, 1'b0, 7'd4);
    rd("rd_w2", 32'h8, 1'b1, 32'h0022_1820);
    rd("rd_past_end", 32'h10, 1'b1, 32'h0);
    rd("rd_ce_off", 32'h0, 1'b0, 32'h0);
    rd("rd_misalign", 32'h7, 1'b1, 32'h3402_0002);
    rd("rd_w0", 32'h0, 1'b1, 32'h3401_0001);
    rd("rd_hi_bits", 32'h104, 1'b1, 32'h3402_0002);
    rd("rd_w3", 32'hC, 1'b1, 32'h0);

    // Beats in RUN are ignored
    beat(32'hFFFF_FFFF, 1'b1);
    chk_ctl("run_ign", 1'b0, 1'b0, 1'b0, 7'd4);
    rd("run_ign.rom", 32'h0, 1'b1, 32'h3401_0001);

    // Reload with a beat in the same cycle (ignored)
    ld_valid = 1'b1;
    ld_data  = 32'h5555_5555;
    ld_last  = 1'b1;
    pulse_reload();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk_ctl("reload", 1'b1, 1'b1, 1'b0, 7'd0);
    rd("reload.rom", 32'h0, 1'b1, 32'h0);
    beat(32'hDEAD_BEEF, 1'b1);
    chk_ctl("one_word", 1'b0, 1'b0, 1'b0, 7'd1);
    rd("one_w0", 32'h0, 1'b1, 32'hDEAD_BEEF);
    rd("one_w1", 32'h4, 1'b1, 32'h0);

    // Toggling valid with idle gaps, reload in LOAD ignored
    pulse_reload();
    beat(32'hAAAA_0001, 1'b0);
    idle(2);
    pulse_reload();
    chk_ctl("gap", 1'b1, 1'b1, 1'b0, 7'd1);
    beat(32'hAAAA_0002, 1'b1);
    idle(1);
    chk_ctl("toggle", 1'b0, 1'b0, 1'b0, 7'd2);
    rd("tog_w0", 32'h0, 1'b1, 32'hAAAA_0001);
    rd("tog_w1", 32'h4, 1'b1, 32'hAAAA_0002);
    rd("tog_w2", 32'h8, 1'b1, 32'h0);

    // Asynchronous reset mid-load
    pulse_reload();
    beat(32'hBBBB_0001, 1'b0);
    beat(32'hBBBB_0002, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_ctl("arst", 1'b1, 1'b1, 1'b0, 7'd0);
    chk("arst.rom", 64'(rom_data), 64'h0);
    ld_valid = 1'b1;
    ld_data  = 32'hBAD0_BAD0;
    ld_last  = 1'b1;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    rst      = 1'b0;
    chk_ctl("arst_beat", 1'b1, 1'b1, 1'b0, 7'd0);
    beat(32'h1111_1111, 1'b1);
    chk_ctl("arst_reload", 1'b0, 1'b0, 1'b0, 7'd1);
    rd("arst_w0", 32'h0, 1'b1, 32'h1111_1111);
    rd("arst_w1", 32'h4, 1'b1, 32'h0);

    // Overflow: 64 beats without last
    pulse_reload();
    for (int i = 0; i < 64; i++) begin
      beat(32'hA000_0000 + 32'(i), 1'b0);
      if (i == 62) chk_ctl("ovf63", 1'b1, 1'b1, 1'b0, 7'd63);
    end
    chk_ctl("ovf", 1'b0, 1'b1, 1'b1, 7'd64);
    beat(32'hC0C0_C0C0, 1'b1);
    chk_ctl("ovf_65", 1'b0, 1'b1, 1'b1, 7'd64);
    pulse_reload();
    chk_ctl("ovf_reload", 1'b0, 1'b1, 1'b1, 7'd64);
    rd("ovf.rom", 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_ctl("ovf_rst", 1'b1, 1'b1, 1'b0, 7'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(32'h0000_00AA, 1'b0);
    beat(32'h0000_00BB, 1'b1);
    chk_ctl("post_ovf", 1'b0, 1'b0, 1'b0, 7'd2);
    rd("post_w1", 32'h4, 1'b1, 32'h0000_00BB);
    rd("post_w2", 32'h8, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
